foreach_row_sequencer: RTL and testbench

//  Executes the FOREACH vector op (opcode 4'b1111: "foreach row in cache-colour region, row <<= SHAMT").

---
 rtl/foreach_row_sequencer_if.sv | 37 +++
 rtl/foreach_row_sequencer.sv | 110 +++++++++++
 tb/tb_foreach_row_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/foreach_row_sequencer_if.sv
// Bus bundle between the processor core and the FOREACH row sequencer.
// master: core/memory side (drives start/abort/operands and the memory response).
// slave : sequencer side (drives the memory request and the status pulses).
//   start, abort        control from decode
//   baseAddr, rowCount  operands sampled on an accepted start
//   memRData, memReady  memory read data / access-complete strobe
//   memAddr, memWData   memory request address / write data
//   MRE, MWE            memory read / write enables
//   busy, done, aborted status: stall request, completion pulse, cancel pulse
interface foreach_row_sequencer_if #(
  parameter int unsigned MBUS = 32,
  parameter int unsigned CBUS = 16
);
  logic            start;
  logic            abort;
  logic [MBUS-1:0] baseAddr;
  logic [CBUS-1:0] rowCount;
  logic [MBUS-1:0] memRData;
  logic            memReady;
  logic [MBUS-1:0] memAddr;
  logic [MBUS-1:0] memWData;
  logic            MRE;
  logic            MWE;
  logic            busy;
  logic            done;
  logic            aborted;

  modport master (
    output start, abort, baseAddr, rowCount, memRData, memReady,
    input  memAddr, memWData, MRE, MWE, busy, done, aborted
  );

  modport slave (
    input  start, abort, baseAddr, rowCount, memRData, memReady,
    output memAddr, memWData, MRE, MWE, busy, done, aborted
  );
endinterface

// File: rtl/foreach_row_sequencer.sv
// FOREACH vector-op sequencer: for each of rowCount rows starting at baseAddr
// (STRIDE bytes apart) read the row, shift it left by SHAMT and write it back.
// Owns the data-memory port while busy; the core stalls on busy.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous reset, active-low
//   bus  foreach_row_sequencer_if slave modport (control, operands, memory port, status)
module foreach_row_sequencer #(
  parameter int unsigned MBUS   = 32,
  parameter int unsigned CBUS   = 16,
  parameter int unsigned STRIDE = 4,
  parameter int unsigned SHAMT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  foreach_row_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CBUS-1:0] idx, idx_n;
  logic [CBUS-1:0] count, count_n;
  logic [MBUS-1:0] addr, addr_n;
  logic [MBUS-1:0] row, row_n;
  logic            aborted_q, aborted_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      count     <= '0;
      addr      <= '0;
      row       <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      count     <= count_n;
      addr      <= addr_n;
      row       <= row_n;
      aborted_q <= aborted_n;
    end
  end

  // The row address is kept as a running sum (base + idx*STRIDE built up by
  // adding STRIDE per row) instead of a multiply; wraps modulo 2^MBUS.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    count_n   = count;
    addr_n    = addr;
    row_n     = row;
    aborted_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          addr_n  = bus.baseAddr;
          count_n = bus.rowCount;
          idx_n   = '0;
          state_n = (bus.rowCount == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (bus.memReady) begin
          row_n   = bus.memRData << SHAMT;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (bus.memReady) begin
          if (idx == count - CBUS'(1)) begin
            state_n = FINISH;
          end else begin
            idx_n   = idx + CBUS'(1);
            addr_n  = addr + MBUS'(STRIDE);
            state_n = READ;
          end
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Abort overrides any progress in an active state; in IDLE it only blocks start.
    if (state != IDLE && bus.abort) begin
      state_n   = IDLE;
      aborted_n = 1'b1;
    end
  end

  // All outputs decode registered state only, so they are stable for the
  // whole of any access that is waiting on memReady.
  always_comb begin
    bus.MRE      = (state == READ);
    bus.MWE      = (state == WRITE);
    bus.memAddr  = (state == READ || state == WRITE) ? addr : '0;
    bus.memWData = (state == WRITE) ? row : '0;
    bus.busy     = (state != IDLE);
    bus.done     = (state == FINISH);
    bus.aborted  = aborted_q;
  end

endmodule

// File: tb/tb_foreach_row_sequencer.sv
module tb_foreach_row_sequencer;
  localparam int unsigned MBUS   = 32;
  localparam int unsigned CBUS   = 16;
  localparam int unsigned STRIDE = 4;
  localparam int unsigned SHAMT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edges = 0;
  int   vectors = 0;
  int   miscompares = 0;

  foreach_row_sequencer_if #(.MBUS(MBUS), .CBUS(CBUS)) bus();

  foreach_row_sequencer #(
    .MBUS(MBUS), .CBUS(CBUS), .STRIDE(STRIDE), .SHAMT(SHAMT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // memory image and model of expected writes, in order
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          stall_q[$];

  int   pending = 0;
  bit   fresh = 1'b1;
  bit   prev_wait = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [1:0]  prev_en;
  int   done_cnt, done_edge, abort_cnt, busy_cnt, write_cnt;
  int   acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // memory responder + per-cycle compare, sampled mid-cycle
  always @(negedge clk) begin
    logic active, cancel;
    active = bus.MRE || bus.MWE;
    cancel = !rst || bus.abort;

    if (active && !cancel) begin
      if (fresh) begin
        pending = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        fresh = 1'b0;
      end
      if (pending > 0) begin
        bus.memReady = 1'b0;
        pending--;
      end else begin
        bus.memReady = 1'b1;
        fresh = 1'b1;
      end
    end else begin
      bus.memReady = 1'b1;
      fresh = 1'b1;
    end
    bus.memRData = mem.exists(bus.memAddr) ? mem[bus.memAddr] : 32'hDEAD_BEEF;

    check("mre_mwe_exclusive", bus.MRE & bus.MWE, 0);
    if (prev_wait) begin
      check("hold_addr", bus.memAddr, prev_addr);
      check("hold_wdata", bus.memWData, prev_wdata);
      check("hold_enables", {bus.MRE, bus.MWE}, prev_en);
    end
    if (active && !cancel) begin
      if (exp_addr.size() == 0) begin
        check("stray_access", {bus.MRE, bus.MWE}, 0);
      end else if (bus.memReady) begin
        check(bus.MRE ? "read_addr" : "write_addr", bus.memAddr, exp_addr[0]);
        if (bus.MWE) begin
          check("write_data", bus.memWData, exp_data[0]);
          wlog_addr.push_back(bus.memAddr);
          wlog_data.push_back(bus.memWData);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
          write_cnt++;
        end
      end
    end
    prev_wait  = active && !cancel && !bus.memReady;
    prev_addr  = bus.memAddr;
    prev_wdata = bus.memWData;
    prev_en    = {bus.MRE, bus.MWE};

    if (bus.done) begin done_cnt++; done_edge = edges; end
    if (bus.aborted) abort_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic clear_counts();
    done_cnt = 0; done_edge = -1; abort_cnt = 0; busy_cnt = 0; write_cnt = 0;
    wlog_addr.delete(); wlog_data.delete();
  endtask

  // Builds the expected write list for the op, then pulses start for one cycle.
  task automatic begin_op(input logic [31:0] base, input int n);
    logic [31:0] a, d;
    clear_counts();
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i) * STRIDE;
      if (!mem.exists(a)) mem[a] = a ^ 32'hA5C3_0F1E;
      d = mem[a] * 32'd256;
      exp_addr.push_back(a);
      exp_data.push_back(d);
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.baseAddr = base; bus.rowCount = 16'(n);
    @(posedge clk); #1;
    acc = edges;
    bus.start = 1'b0;
  endtask

  task automatic finish_op(input int n, input int extra);
    for (int k = 0; k < 400 && done_cnt == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("done_cycle", done_edge - acc, 2 * n + extra);
    check("busy_cycles", busy_cnt, 2 * n + 1 + extra);
    check("write_count", write_cnt, n);
    check("pending_writes", exp_addr.size(), 0);
    check("aborted_count", abort_cnt, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.baseAddr = '0; bus.rowCount = '0;
    bus.memReady = 1'b1; bus.memRData = '0;
    clear_counts();

    // reset held two cycles with start asserted
    rst = 1'b0; bus.start = 1'b1; bus.baseAddr = 32'h100; bus.rowCount = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", {bus.memAddr, bus.memWData}, 0);
    check("reset_ctrl", {bus.MRE, bus.MWE, bus.busy, bus.done, bus.aborted}, 0);
    rst = 1'b1; bus.start = 1'b0;
    clear_counts();
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_busy", busy_cnt, 0);
    check("post_reset_done", done_cnt, 0);

    // base run: three rows, zero-wait memory
    mem[32'h100] = 32'h0000_00AB;
    mem[32'h104] = 32'h1234_5678;
    mem[32'h108] = 32'hFFFF_FFFF;
    begin_op(32'h100, 3);
    finish_op(3, 0);
    check("base_done_offset", done_edge - acc, 6);
    check("base_nwrites", wlog_addr.size(), 3);
    if (wlog_addr.size() == 3) begin
      check("base_w0", {wlog_addr[0], wlog_data[0]}, {32'h100, 32'h0000_AB00});
      check("base_w1", {wlog_addr[1], wlog_data[1]}, {32'h104, 32'h3456_7800});
      check("base_w2", {wlog_addr[2], wlog_data[2]}, {32'h108, 32'hFFFF_FF00});
    end

    // wait states: 3 in first read, 2 in first write
    stall_q.push_back(3);
    stall_q.push_back(2);
    begin_op(32'h300, 2);
    finish_op(2, 5);
    check("wait_done_offset", done_edge - acc, 9);

    // zero rows
    begin_op(32'h400, 0);
    finish_op(0, 0);

    // address wrap
    begin_op(32'hFFFF_FFFC, 2);
    finish_op(2, 0);
    check("wrap_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      check("wrap_a0", wlog_addr[0], 32'hFFFF_FFFC);
      check("wrap_a1", wlog_addr[1], 32'h0000_0000);
    end

    // start while busy is ignored
    begin_op(32'h500, 4);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.baseAddr = 32'h900; bus.rowCount = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_op(4, 0);

    // abort in the write of row 1
    begin_op(32'h200, 4);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_mwe", bus.MWE, 1);
    check("abort_pre_addr", bus.memAddr, 32'h204);
    bus.abort = 1'b1;
    exp_addr.delete(); exp_data.delete();
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_pulse_now", bus.aborted, 1);
    check("abort_idle_en", {bus.MRE, bus.MWE, bus.busy}, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_count", abort_cnt, 1);
    check("abort_no_done", done_cnt, 0);
    check("abort_writes", write_cnt, 1);
    begin_op(32'h600, 2);
    finish_op(2, 0);

    // reset in the write of row 1
    begin_op(32'h200, 4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr.delete(); exp_data.delete();
    @(posedge clk); #1;
    check("midrst_data", {bus.memAddr, bus.memWData}, 0);
    check("midrst_ctrl", {bus.MRE, bus.MWE, bus.busy, bus.done, bus.aborted}, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_abort", abort_cnt, 0);
    check("midrst_no_done", done_cnt, 0);
    begin_op(32'h700, 3);
    finish_op(3, 0);

    // abort and start together in IDLE: nothing starts, no pulse
    clear_counts();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.baseAddr = 32'h800; bus.rowCount = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_start_busy", busy_cnt, 0);
    check("abort_start_pulse", abort_cnt, 0);
    check("abort_start_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
